// File: rtl/hot_buf_pkg.sv
// Shared types for the hot buffer, its reader and the MLU input stage.
// Rows are unpacked lane arrays so all three blocks agree on one row layout.
package hot_buf_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = 16;
  localparam int DEPTH  = 256;
  localparam int IDX_W  = $clog2(DEPTH);

  typedef logic [DATA_W-1:0] row_t [LANES-1:0];

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/hot_row_fifo.sv
// Small row queue: a push is visible at the head the cycle after it lands; push and pop may share a cycle.
// No backpressure of its own: the writer must hold credit, pushing while full is a protocol error.
module hot_row_fifo
  import hot_buf_pkg::*;
#(
  parameter int ENTRIES = 2,
  localparam int CNT_W  = $clog2(ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  row_t             push_dat_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  output row_t             head_dat_o,
  output logic             head_last_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  row_t             mem_q  [ENTRIES];
  logic             last_q [ENTRIES];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o      = (count_q == CNT_W'(ENTRIES));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_dat_o  = mem_q[rd_ptr_q];
  assign head_last_o = last_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(ENTRIES - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(ENTRIES - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q]  <= push_dat_i;
      last_q[wr_ptr_q] <= push_last_i;
    end
  end

  no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));

endmodule

// File: rtl/hot_buffer_reader.sv
// Reads cmd_len rows from cmd_base, first row valid two edges after accept, then one row per cycle.
// Reads are only issued with a free queue slot reserved, so row_ready stalls never lose or repeat a row.
module hot_buffer_reader
  import hot_buf_pkg::*;
#(
  parameter int OQ_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IDX_W-1:0] cmd_base,
  input  logic [IDX_W:0]   cmd_len,
  output logic             buf_read_en,
  output logic [IDX_W-1:0] buf_idx,
  input  logic             buf_write_en,
  input  row_t             buf_rdata,
  output logic             row_valid,
  input  logic             row_ready,
  output row_t             row_data,
  output logic             row_last,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(OQ_DEPTH + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] next_idx_q, next_idx_d;
  logic [IDX_W:0]   remaining_q, remaining_d;
  logic             inflight_q, inflight_d;
  logic             inflight_last_q, inflight_last_d;

  logic [CNT_W-1:0] oq_count;
  logic             oq_full, oq_empty, oq_last;
  logic [CNT_W:0]   occ_after;
  logic             cmd_fire, pop, issue, drained, last_read;

  assign cmd_fire  = (state_q == IDLE) && cmd_valid;
  assign pop       = row_valid && row_ready;
  assign last_read = (remaining_q == (IDX_W + 1)'(1));

  // Slots committed after this edge: queued rows plus the row already on its way, minus the one leaving.
  assign occ_after = {1'b0, oq_count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);

  assign issue = (state_q == ISSUE) && (remaining_q != '0) && !buf_write_en
              && !(oq_full && !pop) && (occ_after < (CNT_W + 1)'(OQ_DEPTH));

  assign drained = !inflight_q && (oq_count == CNT_W'(pop));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = (cmd_len == '0) ? DONE : ISSUE;
      ISSUE:   if (issue && last_read) state_d = DRAIN;
      DRAIN:   if (drained) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    buf_read_en = issue;
    buf_idx     = next_idx_q;
    case (state_q)
      IDLE:         cmd_ready = 1'b1;
      ISSUE, DRAIN: busy      = 1'b1;
      DONE:         done      = 1'b1;
      default:      cmd_ready = 1'b0;
    endcase
  end

  always_comb begin
    next_idx_d      = next_idx_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = issue && last_read;
    if (cmd_fire) begin
      next_idx_d  = cmd_base;
      remaining_d = cmd_len;
    end else if (issue) begin
      next_idx_d  = next_idx_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_idx_q      <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      next_idx_q      <= next_idx_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  hot_row_fifo #(
    .ENTRIES (OQ_DEPTH)
  ) u_oq (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (inflight_q),
    .push_dat_i  (buf_rdata),
    .push_last_i (inflight_last_q),
    .pop_i       (pop),
    .head_dat_o  (row_data),
    .head_last_o (oq_last),
    .count_o     (oq_count),
    .full_o      (oq_full),
    .empty_o     (oq_empty)
  );

  assign row_valid = !oq_empty;
  // Head storage is unreset, so mask its last flag until a real row sits there.
  assign row_last  = oq_last && row_valid;

endmodule

// File: tb/tb_hot_buffer_reader.sv
// Directed bench for hot_buffer_reader with a one-cycle-latency hot buffer model and a row scoreboard.
module tb_hot_buffer_reader;
  import hot_buf_pkg::*;

  localparam int ROW_BITS = DATA_W * LANES;
  localparam int OQ       = 2;

  logic             clk, rst;
  logic             cmd_valid, cmd_ready;
  logic [IDX_W-1:0] cmd_base, buf_idx;
  logic [IDX_W:0]   cmd_len;
  logic             buf_read_en, buf_write_en;
  row_t             buf_rdata, row_data;
  logic             row_valid, row_ready, row_last, busy, done;

  row_t mem [DEPTH];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, accept_s = -1, first_valid_s = -1, last_pop_s = -1, done_s = -1;
  int pops = 0, reads = 0, dones = 0, occ = 0, max_occ = 0;
  int r_exp;
  bit l_exp;
  bit rd_d1 = 0, rd_d2 = 0, pop_prev = 0, stall_prev = 0;
  logic [ROW_BITS-1:0] prev_dat;
  int exp_row[$];
  bit exp_last[$];
  int exp_rd[$];

  hot_buffer_reader #(.OQ_DEPTH(OQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_base     (cmd_base),
    .cmd_len      (cmd_len),
    .buf_read_en  (buf_read_en),
    .buf_idx      (buf_idx),
    .buf_write_en (buf_write_en),
    .buf_rdata    (buf_rdata),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .row_data     (row_data),
    .row_last     (row_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (buf_read_en) buf_rdata <= mem[buf_idx];
  end

  function automatic logic [ROW_BITS-1:0] pack_row(input row_t r);
    logic [ROW_BITS-1:0] p;
    for (int j = 0; j < LANES; j++) p[j*DATA_W +: DATA_W] = r[j];
    return p;
  endfunction

  task automatic expect_eq(input string tag, input logic [ROW_BITS-1:0] got,
                           input logic [ROW_BITS-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Scoreboard sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      occ = 0; rd_d1 = 0; rd_d2 = 0; pop_prev = 0; stall_prev = 0;
    end else begin
      cyc++;
      occ = occ + int'(rd_d2) - int'(pop_prev);
      if (occ > max_occ) max_occ = occ;
      expect_eq("row_valid_vs_model", row_valid, occ != 0);
      if (stall_prev) begin
        expect_eq("stall_valid", row_valid, 1);
        expect_eq("stall_data", pack_row(row_data), prev_dat);
      end
      if (cmd_valid && cmd_ready) accept_s = cyc;
      if (buf_write_en) expect_eq("rd_during_wr", buf_read_en, 0);
      if (buf_read_en) begin
        reads++;
        if (exp_rd.size() == 0) expect_eq("rd_extra", exp_rd.size(), 1);
        else expect_eq("rd_idx", buf_idx, exp_rd.pop_front());
      end
      if (row_valid && first_valid_s < 0) first_valid_s = cyc;
      if (row_valid && row_ready) begin
        pops++;
        last_pop_s = cyc;
        if (exp_row.size() == 0) expect_eq("pop_extra", exp_row.size(), 1);
        else begin
          r_exp = exp_row.pop_front();
          l_exp = exp_last.pop_front();
          expect_eq("row_data", pack_row(row_data), pack_row(mem[r_exp]));
          expect_eq("row_last", row_last, l_exp);
        end
      end
      if (done) begin
        dones++;
        done_s = cyc;
      end
      stall_prev = row_valid && !row_ready;
      prev_dat   = pack_row(row_data);
      rd_d2      = rd_d1;
      rd_d1      = buf_read_en;
      pop_prev   = row_valid && row_ready;
    end
  end

  task automatic check_reset(input string tag);
    expect_eq({tag, "_cmd_ready"}, cmd_ready, 1);
    expect_eq({tag, "_busy"}, busy, 0);
    expect_eq({tag, "_done"}, done, 0);
    expect_eq({tag, "_row_valid"}, row_valid, 0);
    expect_eq({tag, "_row_last"}, row_last, 0);
    expect_eq({tag, "_read_en"}, buf_read_en, 0);
    expect_eq({tag, "_idx"}, buf_idx, 0);
  endtask

  task automatic start_cmd(input int base, input int len);
    @(negedge clk);
    cmd_base  = IDX_W'(base);
    cmd_len   = (IDX_W + 1)'(len);
    cmd_valid = 1'b1;
    for (int i = 0; i < len; i++) begin
      exp_rd.push_back((base + i) % DEPTH);
      exp_row.push_back((base + i) % DEPTH);
      exp_last.push_back(i == len - 1);
    end
    pops = 0; reads = 0; dones = 0; max_occ = 0;
    first_valid_s = -1; last_pop_s = -1; done_s = -1; accept_s = -1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit toggle);
    int k;
    k = 0;
    #2;
    while (dones == 0 && k < budget) begin
      @(negedge clk);
      if (toggle) row_ready = (k % 6 == 0) || (k % 6 == 3) || (k % 6 == 5);
      k++;
      #2;
    end
    if (dones == 0) expect_eq({tag, "_done_timeout"}, dones, 1);
  endtask

  task automatic finish_cmd(input string tag, input int len, input int lat);
    expect_eq({tag, "_pops"}, pops, len);
    expect_eq({tag, "_reads"}, reads, len);
    expect_eq({tag, "_leftover"}, exp_row.size(), 0);
    if (lat >= 0) expect_eq({tag, "_latency"}, done_s - accept_s, lat);
    expect_eq({tag, "_done_busy"}, busy, 0);
    expect_eq({tag, "_done_cmd_ready"}, cmd_ready, 0);
    expect_eq({tag, "_max_occ"}, max_occ <= OQ, 1);
    row_ready = 1'b1;
    @(negedge clk);
    #2;
    expect_eq({tag, "_idle_cmd_ready"}, cmd_ready, 1);
    expect_eq({tag, "_done_pulses"}, dones, 1);
  endtask

  initial begin
    for (int r = 0; r < DEPTH; r++)
      for (int j = 0; j < LANES; j++) mem[r][j] = {16'(r), 16'(j)};
    rst = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0;
    buf_write_en = 1'b0; row_ready = 1'b1;
    @(negedge clk);
    #2;
    check_reset("rst0");
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back rows 0..7.
    start_cmd(0, 8);
    wait_done("t1", 40, 0);
    expect_eq("t1_first_valid", first_valid_s - accept_s, 3);
    expect_eq("t1_no_gaps", last_pop_s - first_valid_s, 7);
    expect_eq("t1_done_after_pop", done_s - last_pop_s, 1);
    finish_cmd("t1", 8, 11);

    // Index wrap 250..255, 0..3.
    start_cmd(250, 10);
    wait_done("t2", 40, 0);
    finish_cmd("t2", 10, 13);

    // Downstream stalls.
    start_cmd(16, 6);
    wait_done("t3", 80, 1);
    finish_cmd("t3", 6, -1);

    // Writes block the 2nd and 3rd reads.
    start_cmd(0, 4);
    #2;
    expect_eq("t4_rd0_en", buf_read_en, 1);
    expect_eq("t4_rd0_idx", buf_idx, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      buf_write_en = 1'b1;
      #2;
      expect_eq("t4_blocked_en", buf_read_en, 0);
      expect_eq("t4_held_idx", buf_idx, 1);
    end
    @(negedge clk);
    buf_write_en = 1'b0;
    #2;
    expect_eq("t4_retry_en", buf_read_en, 1);
    expect_eq("t4_retry_idx", buf_idx, 1);
    wait_done("t4", 40, 0);
    finish_cmd("t4", 4, 9);

    // Empty command, then a full-buffer sweep from 128.
    start_cmd(0, 0);
    wait_done("t5a", 10, 0);
    expect_eq("t5a_no_valid", first_valid_s, -1);
    finish_cmd("t5a", 0, 1);
    start_cmd(128, 256);
    wait_done("t5b", 400, 0);
    expect_eq("t5b_no_gaps", last_pop_s - first_valid_s, 255);
    finish_cmd("t5b", 256, 259);

    // Reset after three pops drops the command silently.
    start_cmd(0, 8);
    for (int k = 0; k < 40 && pops < 3; k++) begin
      @(negedge clk);
      #2;
    end
    expect_eq("t6_pops_before_rst", pops, 3);
    @(negedge clk);
    rst = 1'b0;
    exp_rd.delete(); exp_row.delete(); exp_last.delete();
    #2;
    check_reset("t6_rst");
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    expect_eq("t6_no_done", dones, 0);
    expect_eq("t6_idle_ready", cmd_ready, 1);
    start_cmd(0, 2);
    wait_done("t6b", 20, 0);
    finish_cmd("t6b", 2, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
